// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch-side initiator for the instruction memory. Holds the fetch PC, drives
// it as the memory address, captures each returned word with its PC into a
// small prefetch FIFO and presents {pc, inst} pairs to decode over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch at
// the redirect target.
//
// Parameters
//   REG_SIZE    data/address width
//   RESET_PC    fetch PC loaded on reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   imem_addr_o    byte address to instruction memory (registered fetch PC)
//   imem_inst_i    word returned combinationally for imem_addr_o
//   redirect_i     flush FIFO and restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target byte address
//   inst_valid_o   FIFO head holds a valid pair
//   inst_ready_i   decode accepts the head this cycle
//   inst_o         instruction at FIFO head (0 when empty)
//   pc_o           PC of inst_o (0 when empty)
//   misalign_o     misaligned-redirect trap flag (IFU_MISALIGN_TRAP_EN only)
//
// Build option
//   IFU_MISALIGN_TRAP_EN : when defined, a redirect to a non-word-aligned
//   target raises misalign_o and halts fetch until the next aligned
//   redirect. When undefined, the low two target bits are masked off and
//   the misalign_o port does not exist.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                  REG_SIZE   = 32,
    parameter logic [REG_SIZE-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [REG_SIZE-1:0] imem_addr_o,
    input  logic [REG_SIZE-1:0] imem_inst_i,
    input  logic                redirect_i,
    input  logic [REG_SIZE-1:0] redirect_pc_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [REG_SIZE-1:0] inst_o,
    output logic [REG_SIZE-1:0] pc_o
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic                misalign_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [REG_SIZE-1:0] r_fetch_pc;
    logic [REG_SIZE-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [REG_SIZE-1:0] r_mem_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_halt;
    logic [REG_SIZE-1:0] w_redirect_pc;

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_misalign;

    // Trap flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_i) begin
            r_misalign <= |redirect_pc_i[1:0];
        end else begin
            r_misalign <= r_misalign;
        end
    end

    // Trapped targets are loaded unmasked so the faulting address is visible.
    assign w_halt        = r_misalign;
    assign w_redirect_pc = redirect_pc_i;
    assign misalign_o    = r_misalign;
`else
    // Without the trap, force the target onto a word boundary.
    assign w_halt        = 1'b0;
    assign w_redirect_pc = redirect_pc_i & {{(REG_SIZE-2){1'b1}}, 2'b00};
`endif

    assign imem_addr_o = r_fetch_pc;

    // Handshake: a redirect cycle neither pops nor pushes; a full FIFO may
    // still push when the head leaves in the same cycle.
    always_comb begin
        w_valid = (r_count != {CNT_W{1'b0}});
        w_pop   = w_valid & inst_ready_i & ~redirect_i;
        w_push  = ~redirect_i & ~w_halt &
                  ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);
    end

    // Head presentation: pair from the read pointer, zeroed while empty.
    always_comb begin
        inst_valid_o = w_valid;
        if (w_valid) begin
            inst_o = r_mem_inst[r_rd_ptr];
            pc_o   = r_mem_pc[r_rd_ptr];
        end else begin
            inst_o = {REG_SIZE{1'b0}};
            pc_o   = {REG_SIZE{1'b0}};
        end
    end

    // Fetch PC, FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_pc[i]   <= {REG_SIZE{1'b0}};
                r_mem_inst[i] <= {REG_SIZE{1'b0}};
            end
        end else if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
                r_mem_inst[r_wr_ptr] <= imem_inst_i;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
                // Wraps modulo 2^REG_SIZE by construction.
                r_fetch_pc           <= r_fetch_pc + REG_SIZE'(4);
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
